seq_alu: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 20 ++
 rtl/seq_muldiv.sv | 87 ++++++++
 rtl/seq_alu.sv | 158 +++++++++++++++
 tb/tb_seq_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// alu_pkg: shared opcode encodings and FSM state type for the sequential ALU
// (seq_alu) and its iterative multiply/divide datapath (seq_muldiv).
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned multiply (shift-add) / divide (restoring),
// one step per clock for W steps after a load.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture a, b, is_div and start a W-step run
//   is_div   : 1 = divide a/b, 0 = multiply a*b
//   a, b     : operands
//   lo, hi   : value of the working registers AFTER the current step
//              (MUL: product low/high halves, DIV: quotient/remainder)
//   fin      : the current step is the last one; lo/hi are final this cycle
module seq_muldiv #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         fin
);
  import alu_pkg::*;

  logic [W-1:0]  lo_q;    // MUL: multiplier shifting out; DIV: dividend -> quotient
  logic [W-1:0]  hi_q;    // MUL: partial product high half; DIV: remainder
  logic [W-1:0]  opnd_q;  // MUL: multiplicand; DIV: divisor
  logic          div_q;
  logic          run_q;
  logic [CW-1:0] cnt_q;

  logic [W:0] sum;
  logic [W:0] shifted;

  // Outputs are the next-step values so the owner can register the final
  // result on the same edge the last step completes, keeping latency at W+1.
  always_comb begin
    lo      = '0;
    hi      = '0;
    sum     = '0;
    shifted = '0;
    if (div_q) begin
      shifted = {hi_q, lo_q[W-1]};
      if (shifted >= {1'b0, opnd_q}) begin
        // Remainder after a successful subtract is < divisor, so W bits suffice.
        hi = shifted[W-1:0] - opnd_q;
        lo = {lo_q[W-2:0], 1'b1};
      end else begin
        hi = shifted[W-1:0];
        lo = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      {hi, lo} = {sum, lo_q[W-1:1]};
    end
  end

  assign fin = run_q && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      lo_q   <= is_div ? a : b;
      opnd_q <= is_div ? b : a;
      hi_q   <= '0;
      div_q  <= is_div;
      run_q  <= 1'b1;
      cnt_q  <= CW'(W - 1);
    end else if (run_q) begin
      lo_q <= lo;
      hi_q <= hi;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with start/done handshake. Single-cycle ops finish
// two edges after start; MUL/DIV iterate W cycles in seq_muldiv.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only when idle (op, a, b latched with it)
//   op, a, b : opcode and unsigned operands
//   busy     : high whenever the FSM is not idle
//   done     : one-cycle pulse; result/flags valid from this cycle
//   result   : registered result, held until the next operation completes
//   carry    : carry / borrow / multiply overflow / shifted-out bit
//   zero     : result == 0
//   err      : divide by zero
module seq_alu #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         err
);
  import alu_pkg::*;

  state_t       state_q;
  logic [2:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  logic         md_load;
  logic [W-1:0] md_lo;
  logic [W-1:0] md_hi;
  logic         md_fin;

  logic [W-1:0] sc_res;
  logic         sc_carry;
  logic [W:0]   wide;

  // Divide by zero never starts the iterative datapath.
  assign md_load = (state_q == IDLE) && start &&
                   ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));

  seq_muldiv #(
    .W  (W),
    .CW (CW)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (md_load),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .lo     (md_lo),
    .hi     (md_hi),
    .fin    (md_fin)
  );

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    wide     = '0;
    case (op_q)
      OP_AND: sc_res = a_q & b_q;
      OP_OR:  sc_res = a_q | b_q;
      OP_ADD: begin
        wide     = {1'b0, a_q} + {1'b0, b_q};
        sc_res   = wide[W-1:0];
        sc_carry = wide[W];
      end
      OP_SUB: begin
        // Bit W of the extended difference is the borrow (a < b).
        wide     = {1'b0, a_q} - {1'b0, b_q};
        sc_res   = wide[W-1:0];
        sc_carry = wide[W];
      end
      OP_SHL: begin
        sc_res   = {a_q[W-2:0], 1'b0};
        sc_carry = a_q[W-1];
      end
      OP_SHR: begin
        sc_res   = {1'b0, a_q[W-1:1]};
        sc_carry = a_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if ((op_q == OP_DIV) && (b_q == '0)) begin
            result  <= '1;
            carry   <= 1'b0;
            zero    <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state_q <= DONE;
          end else if ((op_q == OP_MUL) || (op_q == OP_DIV)) begin
            if (md_fin) begin
              result  <= md_lo;
              carry   <= (op_q == OP_MUL) && (|md_hi);
              zero    <= (md_lo == '0);
              err     <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            result  <= sc_res;
            carry   <= sc_carry;
            zero    <= (sc_res == '0);
            err     <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at W=4.
module tb_seq_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, outputs, the done pulse width
  // and that results hold afterwards.
  task automatic do_op(input string name, input logic [2:0] o,
                       input logic [3:0] x, input logic [3:0] y,
                       input int exp_lat, input int er, input int ec,
                       input int ez, input int ee);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check({name, " busy"}, int'(busy), 1);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " result"}, int'(result), er);
    check({name, " carry"}, int'(carry), ec);
    check({name, " zero"}, int'(zero), ez);
    check({name, " err"}, int'(err), ee);
    @(posedge clk); #1;
    check({name, " done low"}, int'(done), 0);
    check({name, " idle"}, int'(busy), 0);
    @(posedge clk); #1;
    check({name, " hold"}, int'(result), er);
  endtask

  initial begin
    int n;
    int dones;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset flags", int'({carry, zero, err}), 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("AND",     OP_AND, 4'b1100, 4'b1010, 2, 4'b1000, 0, 0, 0);
    do_op("OR",      OP_OR,  4'b1100, 4'b0011, 2, 4'b1111, 0, 0, 0);
    do_op("ADD",     OP_ADD, 4'd9,    4'd8,    2, 4'd1,    1, 0, 0);
    do_op("SUB",     OP_SUB, 4'd3,    4'd5,    2, 4'd14,   1, 0, 0);
    do_op("SUB0",    OP_SUB, 4'd5,    4'd5,    2, 4'd0,    0, 1, 0);
    do_op("MUL",     OP_MUL, 4'd5,    4'd3,    5, 4'd15,   0, 0, 0);
    do_op("MUL ovf", OP_MUL, 4'd6,    4'd3,    5, 4'd2,    1, 0, 0);
    do_op("DIV",     OP_DIV, 4'd13,   4'd4,    5, 4'd3,    0, 0, 0);
    do_op("DIV0",    OP_DIV, 4'd7,    4'd0,    2, 4'd15,   0, 0, 1);
    do_op("SHL",     OP_SHL, 4'b1001, 4'd0,    2, 4'b0010, 1, 0, 0);
    do_op("MUL0",    OP_MUL, 4'd0,    4'd9,    5, 4'd0,    0, 1, 0);

    // start while busy must be ignored
    @(negedge clk);
    op = OP_MUL; a = 4'd5; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    op = OP_ADD; a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy ign busy", int'(busy), 1);
    n = 2;
    dones = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy ign latency", n, 5);
    check("busy ign result", int'(result), 15);
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("busy ign done count", dones, 1);
    check("busy ign final", int'(result), 15);

    // reset mid-operation aborts with no done
    @(negedge clk);
    op = OP_MUL; a = 4'd5; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort result", int'(result), 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("abort no done", dones, 0);
    do_op("SHR", OP_SHR, 4'b1001, 4'd0, 2, 4'b0100, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
